axi4_eth_mm_master: RTL and testbench
=====================================

# axi4_eth_mm_master

AXI4-Full burst initiator for the Ethernet MAC subsystem: the master counterpart of the MAC's AXI4 slave. It accepts one command at a time (address, beat count, direction) and performs a single INCR burst. Writes source their data from a local word stream, for example frame words destined for the TX window. Reads deliver data to a local word stream, for example draining the RX window. It sits between a local controller (sequencer, CPU shim or test harness) and the slave's AXI4 port.

## Interface
- `ADDR_WIDTH`, 16: AXI address width.
- `DATA_WIDTH`, 32: AXI data width; 32 or 64 only.
- `ID_WIDTH`, 4: AXI ID width.
- `TXN_ID`, 0: constant driven on `awid`/`arid`.
- `clk` in 1: single clock. All logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_WIDTH: burst start byte address, aligned to DATA_WIDTH/8.
- `cmd_len` in 8: beats minus 1, giving 1..256 beats.
- `wr_data` in DATA_WIDTH / `wr_valid` in 1 / `wr_ready` out 1: write-data stream.
- `rd_data` out DATA_WIDTH / `rd_valid` out 1 / `rd_ready` in 1 / `rd_last` out 1: read-data stream.
- `busy` out 1: a command is in flight.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: completion status; valid when `done`=1, held until the next command is accepted.
- `m_axi_aw{id,addr,len,size,burst,valid}` out / `m_axi_awready` in: write-address channel.
- `m_axi_w{data,strb,last,valid}` out / `m_axi_wready` in: write-data channel.
- `m_axi_b{id,resp,valid}` in / `m_axi_bready` out: write-response channel.
- `m_axi_ar{id,addr,len,size,burst,valid}` out / `m_axi_arready` in: read-address channel.
- `m_axi_r{id,data,resp,last,valid}` in / `m_axi_rready` out: read-data channel.

## Operation
- States: IDLE, AW, W, B, AR, R, DONE.
- `cmd_ready`=1 only in IDLE. On handshake, the block latches addr and len and clears `err`.
  - `cmd_write`=1: go to AW.
  - `cmd_write`=0: go to AR.
- AW/AR drive fixed channel fields:
  - `len` = latched `cmd_len`.
  - `size` = log2(DATA_WIDTH/8).
  - `burst` = 2'b01.
  - `id` = TXN_ID.
- AW/AR: `*valid` is registered high on state entry and held with stable fields until `*ready`. Then go to W or R respectively.
- W (write data follows the AW handshake; W and AW never overlap):
  - Combinational pass-through: `m_axi_wvalid`=`wr_valid`, `wr_ready`=`m_axi_wready`.
  - `wdata`=`wr_data`, `wstrb`=all ones.
  - 8-bit beat counter increments on each W handshake.
  - `wlast`=(count==len).
  - The last handshake goes to B.
- B: `bready`=1. On `bvalid`, set `err` if `bresp`!=2'b00, then go to DONE.
- R:
  - Combinational pass-through: `rready`=`rd_ready`, `rd_valid`=`m_axi_rvalid`, `rd_data`=`rdata`.
  - `rd_last`=(count==len).
  - Each handshake increments the counter.
  - Set `err` on any of: `rresp`!=0, `rlast`=1 before the final beat, or `rlast`=0 on the final beat.
  - The final counted beat goes to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- Counter width is 8 bits, so it never wraps within a burst; len=255 gives 256 beats.
- `wr_ready`=0 and `rd_valid`=0 in all states other than W and R.

## Timing
- Reset values:
  - All `*valid` outputs, `bready`, `rready`, `wr_ready`, `rd_valid`, `done`, `err` and `busy` are 0.
  - `cmd_ready`=1.
  - State is IDLE and the counter is 0.
- `cmd_valid`&`cmd_ready` at cycle N gives `awvalid`/`arvalid`=1 at N+1.
- Minimum write latency, with the slave always ready: AW at N+1, W beats at N+2..N+2+len, B at the earliest the cycle after the last W, `done` the cycle after B.
- A new command can be accepted the cycle after `done`.
- `rst` mid-burst immediately returns to the reset state.
  - The AXI transaction is abandoned; the slave must also be reset.
  - No `done` is produced.

## Configuration
- `AXI4_ETH_MM_4K_CHECK_EN` defined: on acceptance, a burst with (addr mod 4096) + (len+1)·DATA_WIDTH/8 > 4096 generates no AXI traffic. The block goes directly to DONE with `err`=1, and `done` pulses 1 cycle after acceptance.
- Undefined: no check is performed; the burst is issued as commanded.

## Structure
- Shared package `eth_axi_pkg`:
  - FSM state enum.
  - AXI burst/resp constants (BURST_INCR, RESP_OKAY, RESP_SLVERR).
  - `axi_size_f(DATA_WIDTH)` function.
- No sub-modules; a single FSM with datapath.

## Test plan
- Write addr 0x1000, len 3, data 0xA0..0xA3, slave always ready: awlen=3, awsize=2, wlast only on the 4th beat, `done` 1 cycle after B, `err`=0.
- Read addr 0x2000, len 7, rresp OKAY, `rd_ready` toggled every other cycle: 8 words in order, `rd_last` on the 8th, no beat lost, `err`=0.
- Write with awready delayed 5 cycles and wready stalls: AW fields stay stable while waiting, beat count is exact, `done` pulses once.
- Faults:
  - Read with rresp=SLVERR on beat 2 gives `err`=1.
  - Read with premature rlast on beat 1 of 4 gives `err`=1, and all 4 beats are still consumed.
  - bresp=2'b10 gives `err`=1.
- Assert `rst` during the W phase at beat 2: next cycle all valids=0, `cmd_ready`=1, no `done`; a following command completes normally.
- With the macro defined, addr 0x0FF8, len 3, 32-bit data: no AW issued, `done` and `err`=1 one cycle after acceptance. With the macro undefined, the same command issues a burst with awlen=3.

Source files
------------

// File: rtl/eth_axi_pkg.sv
// Shared types and AXI constants for the Ethernet MAC AXI4 master/slave pair.
// Holds the master FSM state encoding and the AXI size helper.
package eth_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AXI AxSIZE encoding for a full-width beat; only 32- and 64-bit buses exist here.
    function automatic logic [2:0] axi_size_f(input int data_width);
        return (data_width == 64) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/axi4_eth_mm_master.sv
// AXI4 INCR burst initiator: one command at a time, write data from a local stream, read data to a local stream.
// Define AXI4_ETH_MM_4K_CHECK_EN to reject bursts that would cross a 4 KiB boundary.
module axi4_eth_mm_master
    import eth_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TXN_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,

    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,

    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    rd_last,

    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2:0]              state_dbg,

    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam logic [2:0] AXSIZE = axi_size_f(DATA_WIDTH);

    // Every channel transfers on a cycle where valid and ready are both high; a
    // source holds valid and its payload stable until that cycle, and never
    // waits on ready before raising valid.
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt;
    logic                    last_beat;
    logic                    w_fire;
    logic                    r_fire;

    assign last_beat = (cnt == len_q);
    assign w_fire    = (state == S_W) && wr_valid && m_axi_wready;
    assign r_fire    = (state == S_R) && m_axi_rvalid && rd_ready;
    assign state_dbg = state;

`ifdef AXI4_ETH_MM_4K_CHECK_EN
    // End offset of the burst within its 4 KiB page; anything past 4096 spills over.
    logic [13:0] span_end;
    logic        crosses_4k;
    assign span_end   = 14'(cmd_addr[11:0]) + ((14'(cmd_len) + 14'd1) << AXSIZE);
    assign crosses_4k = (span_end > 14'd4096);
`endif

    assign m_axi_awid    = ID_WIDTH'(TXN_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_arid    = ID_WIDTH'(TXN_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = BURST_INCR;

    // Data channels are pure pass-through while their phase is active.
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wvalid = (state == S_W) && wr_valid;
    assign m_axi_wlast  = (state == S_W) && last_beat;
    assign wr_ready     = (state == S_W) && m_axi_wready;

    assign rd_data      = m_axi_rdata;
    assign rd_valid     = (state == S_R) && m_axi_rvalid;
    assign rd_last      = (state == S_R) && last_beat;
    assign m_axi_rready = (state == S_R) && rd_ready;

    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_rid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            cnt           <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        cnt       <= '0;
                        err       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef AXI4_ETH_MM_4K_CHECK_EN
                        if (crosses_4k) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else
`endif
                        if (cmd_write) begin
                            state         <= S_AW;
                            m_axi_awvalid <= 1'b1;
                        end else begin
                            state         <= S_AR;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (w_fire) begin
                        cnt <= cnt + 8'd1;
                        if (last_beat) begin
                            state        <= S_B;
                            m_axi_bready <= 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) err <= 1'b1;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= S_R;
                    end
                end
                S_R: begin
                    if (r_fire) begin
                        cnt <= cnt + 8'd1;
                        // rlast must agree with our own beat count, not terminate the burst.
                        if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat)) err <= 1'b1;
                        if (last_beat) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_eth_mm_master.sv
// Directed bench for axi4_eth_mm_master: bursts against a behavioural AXI slave with hand-computed expectations.
// Covers the AXI4_ETH_MM_4K_CHECK_EN build and the default build.
module tb_axi4_eth_mm_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic        busy, done, err;
    logic [2:0]  state_dbg;
    logic [3:0]  m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [3:0]  m_axi_arid;
    logic [15:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    axi4_eth_mm_master #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4), .TXN_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .done(done), .err(err), .state_dbg(state_dbg),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    endtask

    // Write burst against a slave model; cycle index 1 is the first cycle after acceptance.
    task automatic run_write(input logic [15:0] addr, input logic [7:0] len, input int aw_delay,
                             input bit stall, input logic [1:0] bresp, input logic [31:0] base,
                             input bit chk_timing, output logic err_o);
        int cyc = 1, aw_wait = 0, aw_hs = 0, aw_cyc = 0, beats = 0, first_w = -1, last_w = 0;
        int b_hs = 0, b_cyc = 0, dones = 0, done_cyc = 0, post = 0;
        bit b_pend = 0, fin = 0;
        err_o = 1'bx;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
        #1 check("wr_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!fin && cyc < 400) begin
            m_axi_awready = (aw_wait >= aw_delay);
            m_axi_wready  = stall ? (cyc % 3 != 0) : 1'b1;
            wr_valid      = (beats <= int'(len)) && (stall ? (cyc % 4 != 1) : 1'b1);
            wr_data       = base + 32'(beats);
            m_axi_bvalid  = b_pend;
            m_axi_bresp   = bresp;
            #1;
            if (m_axi_awvalid) begin
                check("aw_fields", {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst},
                      {4'd0, addr, len, 3'd2, 2'b01});
                if (m_axi_awready) begin aw_hs++; aw_cyc = cyc; end
                else aw_wait++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("wdata", m_axi_wdata, base + 32'(beats));
                check("wlast", m_axi_wlast, (beats == int'(len)));
                check("wstrb", m_axi_wstrb, 4'hF);
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                if (beats == int'(len)) b_pend = 1;
                beats++;
            end
            if (m_axi_bvalid && m_axi_bready) begin b_hs++; b_cyc = cyc; b_pend = 0; end
            if (done) begin dones++; done_cyc = cyc; err_o = err; end
            if (dones > 0) post++;
            if (post >= 3) fin = 1;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        #1;
        check("wr_finished", fin, 1'b1);
        check("wr_aw_count", aw_hs, 1);
        check("wr_beats", beats, int'(len) + 1);
        check("wr_b_count", b_hs, 1);
        check("wr_done_count", dones, 1);
        check("wr_done_after_b", done_cyc, b_cyc + 1);
        check("wr_idle_ready", {cmd_ready, busy}, 2'b10);
        if (chk_timing) begin
            check("wr_aw_cyc", aw_cyc, 1);
            check("wr_first_w_cyc", first_w, 2);
            check("wr_last_w_cyc", last_w, 2 + int'(len));
            check("wr_b_cyc", b_cyc, 3 + int'(len));
        end
    endtask

    task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input bit toggle,
                            input int slverr_beat, input int early_beat, input logic [31:0] base,
                            output logic err_o);
        int cyc = 1, idx = 0, ar_hs = 0, ar_cyc = 0, dones = 0, post = 0;
        bit ar_done = 0, fin = 0;
        logic [31:0] exp_w;
        err_o = 1'bx;
        exp_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
        #1 check("rd_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!fin && cyc < 400) begin
            m_axi_arready = 1'b1;
            m_axi_rvalid  = ar_done && (idx <= int'(len));
            m_axi_rdata   = base + 32'(idx);
            m_axi_rresp   = (idx == slverr_beat) ? 2'b10 : 2'b00;
            m_axi_rlast   = (idx == int'(len)) || (idx == early_beat);
            rd_ready      = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (m_axi_arvalid) begin
                check("ar_fields", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst},
                      {4'd0, addr, len, 3'd2, 2'b01});
                ar_hs++; ar_cyc = cyc; ar_done = 1;
                for (int i = 0; i <= int'(len); i++) exp_q.push_back(base + 32'(i));
            end
            if (rd_valid && rd_ready) begin
                check("rready_pass", m_axi_rready, 1'b1);
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("rd_data", rd_data, exp_w);
                check("rd_last", rd_last, (idx == int'(len)));
                idx++;
            end
            if (done) begin dones++; err_o = err; end
            if (dones > 0) post++;
            if (post >= 3) fin = 1;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        #1;
        check("rd_finished", fin, 1'b1);
        check("rd_ar_count", ar_hs, 1);
        check("rd_ar_cyc", ar_cyc, 1);
        check("rd_beats", idx, int'(len) + 1);
        check("rd_queue_empty", exp_q.size(), 0);
        check("rd_done_count", dones, 1);
    endtask

    initial begin
        logic e;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
        check("rst_local", {wr_ready, rd_valid, done, err, busy}, 5'b0);
        check("rst_state", state_dbg, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back-ready write, exact cycle timing.
        run_write(16'h1000, 8'd3, 0, 0, 2'b00, 32'hA0, 1, e);
        check("wr1_err", e, 1'b0);

        // Read with the local sink ready only every other cycle.
        run_read(16'h2000, 8'd7, 1, -1, -1, 32'hB0, e);
        check("rd1_err", e, 1'b0);

        // Write with a 5-cycle awready delay and W stalls on both sides.
        run_write(16'h1100, 8'd5, 5, 1, 2'b00, 32'hC0, 0, e);
        check("wr2_err", e, 1'b0);

        // SLVERR on beat 2.
        run_read(16'h2100, 8'd3, 0, 2, -1, 32'hD0, e);
        check("rd_slverr_err", e, 1'b1);

        // rlast asserted early on beat 1 of 4; all four beats must still be taken.
        run_read(16'h2200, 8'd3, 0, -1, 1, 32'hE0, e);
        check("rd_early_last_err", e, 1'b1);

        // Write response SLVERR; err stays up while idle.
        run_write(16'h1200, 8'd1, 0, 0, 2'b10, 32'hF0, 0, e);
        check("wr_bresp_err", e, 1'b1);
        check("err_held", err, 1'b1);

        // Reset in the middle of the W phase.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h3000; cmd_len = 8'd3;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; wr_valid = 1'b1; wr_data = 32'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("pre_rst_in_w", state_dbg, 3'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
        check("mid_rst_local", {cmd_ready, busy, done, wr_ready}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("no_done_after_rst", {done, cmd_ready}, 2'b01);
        end
        run_write(16'h3000, 8'd2, 0, 0, 2'b00, 32'h60, 1, e);
        check("post_rst_err", e, 1'b0);

`ifdef AXI4_ETH_MM_4K_CHECK_EN
        // 0xFF8 + 4*4 = 0x1008 crosses the page: rejected without bus traffic.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0FF8; cmd_len = 8'd3;
        #1 check("4k_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 check("4k_done_err", {done, err, m_axi_awvalid, m_axi_arvalid}, 4'b1100);
        @(negedge clk);
        #1 check("4k_after", {done, cmd_ready, m_axi_awvalid}, 3'b010);
`else
        run_write(16'h0FF8, 8'd3, 0, 0, 2'b00, 32'h70, 0, e);
        check("4k_off_err", e, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
